// File: rtl/alu_result_collector.sv
// alu_result_collector: tags ALU results through a LATENCY-stage pipe and queues them in a DEPTH-entry FIFO.
// Optional drop counter enabled by defining ALU_COLL_DROP_CNT_EN; otherwise drop_cnt is tied to 0.
module alu_result_collector #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int LATENCY    = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue,
    input  logic [3:0]                   issue_tag,
    input  logic [DATA_WIDTH:0]          res,
    input  logic                         oflow,
    input  logic                         cout,
    input  logic                         g,
    input  logic                         l,
    input  logic                         e,
    input  logic                         err,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH:0]          out_res,
    output logic [5:0]                   out_flags,
    output logic [3:0]                   out_tag,
    output logic [$clog2(DEPTH):0]       count,
    output logic [7:0]                   drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    logic [LATENCY-1:0]   vld;
    logic [4*LATENCY-1:0] tgs;
    logic [DATA_WIDTH:0]  mres [DEPTH];
    logic [5:0]           mflg [DEPTH];
    logic [3:0]           mtag [DEPTH];
    logic [AW-1:0]        wptr, rptr;
    logic                 cap, full, pop, push;
    assign cap  = vld[LATENCY-1];
    assign full = count == (AW+1)'(DEPTH);
    assign pop  = out_valid & out_ready;
    assign push = cap & (!full | pop);
    always_ff @(posedge clk) begin
        if (rst) begin
            vld   <= '0;
            tgs   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            vld   <= LATENCY'({vld, issue});
            tgs   <= (4*LATENCY)'({tgs, issue_tag});
            wptr  <= wptr + AW'(push);
            rptr  <= rptr + AW'(pop);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            mres[wptr] <= res;
            mflg[wptr] <= {err, oflow, cout, g, l, e};
            mtag[wptr] <= tgs[4*LATENCY-1 -: 4];
        end
    end
    // Outputs come from stored state only; empty FIFO presents zeros.
    assign out_valid = count != '0;
    assign out_res   = out_valid ? mres[rptr] : '0;
    assign out_flags = out_valid ? mflg[rptr] : '0;
    assign out_tag   = out_valid ? mtag[rptr] : '0;
`ifdef ALU_COLL_DROP_CNT_EN
    logic [7:0] drops;
    always_ff @(posedge clk) begin
        if (rst) drops <= '0;
        else if (cap && full && !pop && drops != 8'hff) drops <= drops + 8'd1;
    end
    assign drop_cnt = drops;
`else
    assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_alu_result_collector.sv
// tb_alu_result_collector: directed checks of the result collector (LATENCY=1 and LATENCY=3 instances).
module tb_alu_result_collector;
`ifdef ALU_COLL_DROP_CNT_EN
    localparam bit DEN = 1;
`else
    localparam bit DEN = 0;
`endif
    logic clk = 0, rst = 0, issue = 0, out_ready = 0;
    logic [3:0] issue_tag = 0;
    logic [8:0] res = 0;
    logic oflow = 0, cout = 0, g = 0, l = 0, e = 0, err = 0;
    logic out_valid, o3_valid;
    logic [8:0] out_res, o3_res;
    logic [5:0] out_flags, o3_flags;
    logic [3:0] out_tag, o3_tag;
    logic [2:0] count, o3_count;
    logic [7:0] drop_cnt, o3_drop;
    int n_cmp = 0, n_err = 0;
    logic [3:0] prev_tag = 0;
    logic [3:0] nxt;
    int exp_drop;

    always #5 clk = ~clk;

    alu_result_collector #(.DATA_WIDTH(8), .DEPTH(4), .LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .issue(issue), .issue_tag(issue_tag), .res(res),
        .oflow(oflow), .cout(cout), .g(g), .l(l), .e(e), .err(err),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_flags(out_flags), .out_tag(out_tag), .count(count), .drop_cnt(drop_cnt));

    alu_result_collector #(.DATA_WIDTH(8), .DEPTH(4), .LATENCY(3)) u3 (
        .clk(clk), .rst(rst), .issue(issue), .issue_tag(issue_tag), .res(res),
        .oflow(oflow), .cout(cout), .g(g), .l(l), .e(e), .err(err),
        .out_valid(o3_valid), .out_ready(out_ready), .out_res(o3_res),
        .out_flags(o3_flags), .out_tag(o3_tag), .count(o3_count), .drop_cnt(o3_drop));

    function automatic logic [8:0] fr(logic [3:0] t);
        return 9'(t) * 9'd37 + 9'd5;
    endfunction

    function automatic logic [5:0] fl(logic [3:0] t);
        return {t[0], t[1], ~t[0], t[2], t[3], t[1] ^ t[0]};
    endfunction

    task automatic check(string t, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", t, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; issue = 0; out_ready = 0;
        step();
        rst = 0; prev_tag = 0;
    endtask

    // One cycle: issue (iss, tg) while presenting the result of the previous cycle's tag.
    task automatic cyc(logic iss, logic [3:0] tg);
        res = fr(prev_tag);
        {err, oflow, cout, g, l, e} = fl(prev_tag);
        issue = iss; issue_tag = tg;
        step();
        prev_tag = tg;
    endtask

    initial begin
        do_reset();
        check("rst_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_res", out_res, 0);
        check("rst_flags", out_flags, 0);
        check("rst_tag", out_tag, 0);

        // Basic single result, LATENCY=1
        issue = 1; issue_tag = 3; res = 0; {err, oflow, cout, g, l, e} = 0;
        step();
        check("single_no_fallthru", out_valid, 0);
        issue = 0; res = 9'h0FF; cout = 1;
        step();
        cout = 0;
        check("single_valid", out_valid, 1);
        check("single_res", out_res, 9'h0FF);
        check("single_flags", out_flags, 6'b001000);
        check("single_tag", out_tag, 3);
        out_ready = 1;
        step();
        out_ready = 0;
        check("single_pop_count", count, 0);
        check("single_pop_res", out_res, 0);

        // Overflow: 6 issues into 4 entries
        for (int i = 0; i < 6; i++) cyc(1, 4'(i));
        cyc(0, 0);
        exp_drop = DEN ? 2 : 0;
        check("fill_count", count, 4);
        check("fill_drop", drop_cnt, exp_drop);
        for (int i = 0; i < 4; i++) begin
            check("fill_head_tag", out_tag, i);
            check("fill_head_res", out_res, fr(4'(i)));
            check("fill_head_flags", out_flags, fl(4'(i)));
            out_ready = 1;
            step();
            out_ready = 0;
        end
        check("fill_empty", out_valid, 0);
        out_ready = 1;
        step();
        out_ready = 0;
        check("ready_while_empty", count, 0);

        // Full FIFO, pop and capture on the same edge
        for (int i = 8; i < 12; i++) cyc(1, 4'(i));
        cyc(0, 0);
        check("full_count", count, 4);
        cyc(1, 12);
        out_ready = 1;
        cyc(0, 0);
        out_ready = 0;
        check("full_pop_count", count, 4);
        check("full_pop_drop", drop_cnt, exp_drop);
        check("full_pop_head", out_tag, 9);
        for (int i = 9; i <= 12; i++) begin
            check("full_drain_tag", out_tag, i);
            out_ready = 1;
            step();
            out_ready = 0;
        end
        check("full_drain_count", count, 0);

        // Drop counter saturation
        do_reset();
        for (int i = 0; i < 100; i++) cyc(1, 4'(i));
        check("sat_mid", drop_cnt, DEN ? 95 : 0);
        for (int i = 0; i < 200; i++) cyc(1, 4'(i));
        check("sat_top", drop_cnt, DEN ? 255 : 0);
        cyc(0, 0);
        check("sat_hold", drop_cnt, DEN ? 255 : 0);
        check("sat_count", count, 4);

        // Streaming across pointer wrap
        do_reset();
        check("stream_rst_drop", drop_cnt, 0);
        out_ready = 1;
        nxt = 0;
        for (int i = 0; i < 20; i++) begin
            if (i < 10) cyc(1, 4'(i)); else cyc(0, 0);
            if (out_valid) begin
                check("stream_tag", out_tag, nxt);
                check("stream_res", out_res, fr(nxt));
                nxt = nxt + 1;
            end
        end
        out_ready = 0;
        check("stream_total", nxt, 10);
        check("stream_drop", drop_cnt, 0);
        check("stream_count", count, 0);

        // LATENCY=3 timing
        do_reset();
        issue = 1; issue_tag = 7;
        step();
        issue = 0;
        step();
        step();
        check("lat3_early", o3_valid, 0);
        step();
        check("lat3_valid", o3_valid, 1);
        check("lat3_tag", o3_tag, 7);

        // LATENCY=3 with reset mid-pipeline
        do_reset();
        issue = 1; issue_tag = 5;
        step();
        issue = 0;
        step();
        rst = 1;
        step();
        rst = 0;
        for (int i = 0; i < 6; i++) step();
        check("flush_count", o3_count, 0);
        check("flush_valid", o3_valid, 0);
        check("flush_res", o3_res, 0);
        check("flush_flags", o3_flags, 0);
        check("flush_tag", o3_tag, 0);

        // Issue during reset is ignored
        rst = 1; issue = 1; issue_tag = 2;
        step();
        rst = 0; issue = 0;
        for (int i = 0; i < 5; i++) step();
        check("issue_in_rst_l1", count, 0);
        check("issue_in_rst_l3", o3_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
